// File: rtl/alu_pkg.sv
// ALU operation codes and branch funct3 values for the execute stage.
// The ALU control decoder imports this package as well.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bus and EX/MEM output bus of the execute stage.
// The master modport is the side that drives the beat.
interface idex_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            ALUctrl;
    logic                  ALUsrc;
    logic [2:0]            funct3;
    logic                  is_branch;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;

    modport master (
        output in_valid, ALUctrl, ALUsrc, funct3, is_branch, pc,
               rs1_data, rs2_data, imm, rd_addr, reg_write,
        input  in_ready
    );
    modport slave (
        input  in_valid, ALUctrl, ALUsrc, funct3, is_branch, pc,
               rs1_data, rs2_data, imm, rd_addr, reg_write,
        output in_ready
    );
endinterface

interface exmem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  zero;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] store_data;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic                  reg_write_o;

    modport master (
        output out_valid, alu_result, zero, branch_taken, branch_target,
               store_data, rd_addr_o, reg_write_o,
        input  out_ready
    );
    modport slave (
        input  out_valid, alu_result, zero, branch_taken, branch_target,
               store_data, rd_addr_o, reg_write_o,
        output out_ready
    );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU; undefined ALUctrl codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_op_e'(ALUctrl))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = DATA_WIDTH'($signed(a) >>> shamt);
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, ALU, branch decision and the EX/MEM register
// behind a valid/ready handshake with flush.
module ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    idex_if.slave  id_ex,
    exmem_if.master ex_mem
);

    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero;
    logic                  taken_d;
    logic                  accept;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, target_q, store_q;
    logic                  zero_q, taken_q, reg_write_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;

    assign op_b = id_ex.ALUsrc ? id_ex.imm : id_ex.rs2_data;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a       (id_ex.rs1_data),
        .b       (op_b),
        .ALUctrl (id_ex.ALUctrl),
        .result  (alu_res),
        .zero    (alu_zero)
    );

    // blt/bltu use slt/sltu, so result[0] carries the comparison outcome
    always_comb begin
        taken_d = 1'b0;
        if (id_ex.is_branch) begin
            case (id_ex.funct3)
                F3_BEQ:            taken_d = alu_zero;
                F3_BNE:            taken_d = !alu_zero;
                F3_BLT, F3_BLTU:   taken_d = alu_res[0];
                F3_BGE, F3_BGEU:   taken_d = !alu_res[0];
                default:           taken_d = 1'b0;
            endcase
        end
    end

    assign id_ex.in_ready = !valid_q || ex_mem.out_ready;
    assign accept         = id_ex.in_valid && id_ex.in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)                         valid_d = 1'b0;
        else if (accept)                   valid_d = 1'b1;
        else if (valid_q && ex_mem.out_ready) valid_d = 1'b0;
    end

    // Data registers load only on accept, so a stalled beat cannot change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            store_q     <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                result_q    <= alu_res;
                zero_q      <= alu_zero;
                taken_q     <= taken_d;
                target_q    <= id_ex.pc + id_ex.imm;
                store_q     <= id_ex.rs2_data;
                rd_addr_q   <= id_ex.rd_addr;
                reg_write_q <= id_ex.reg_write;
            end
        end
    end

    assign ex_mem.out_valid     = valid_q;
    assign ex_mem.alu_result    = result_q;
    assign ex_mem.zero          = zero_q;
    assign ex_mem.branch_taken  = taken_q;
    assign ex_mem.branch_target = target_q;
    assign ex_mem.store_data    = store_q;
    assign ex_mem.rd_addr_o     = rd_addr_q;
    assign ex_mem.reg_write_o   = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU sweep, branches, backpressure,
// flush and a random-stall ordering run.
module tb_ex_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    idex_if  id_ex ();
    exmem_if ex_mem ();

    ex_stage dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .id_ex  (id_ex),
        .ex_mem (ex_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [3:0] ctrl, input logic src, input logic [2:0] f3,
                            input logic br, input logic [31:0] pc_v, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm_v);
        id_ex.ALUctrl   = ctrl;
        id_ex.ALUsrc    = src;
        id_ex.funct3    = f3;
        id_ex.is_branch = br;
        id_ex.pc        = pc_v;
        id_ex.rs1_data  = a;
        id_ex.rs2_data  = b;
        id_ex.imm       = imm_v;
    endtask

    task automatic run_beat();
        id_ex.in_valid   = 1'b1;
        ex_mem.out_ready = 1'b1;
        step();
        id_ex.in_valid = 1'b0;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] ctrl, input logic src,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm_v,
                            input logic [31:0] exp);
        set_beat(ctrl, src, F3_BEQ, 1'b0, 32'h0, a, b, imm_v);
        run_beat();
        chk(tag, ex_mem.alu_result, exp);
    endtask

    task automatic br_case(input string tag, input logic [3:0] ctrl, input logic [2:0] f3,
                           input logic br, input logic [31:0] a, input logic [31:0] b,
                           input logic exp_taken);
        set_beat(ctrl, 1'b0, f3, br, 32'h100, a, b, 32'hFFFF_FFF0);
        run_beat();
        chk({tag, "_taken"}, 32'(ex_mem.branch_taken), 32'(exp_taken));
        chk({tag, "_target"}, ex_mem.branch_target, 32'h0000_00F0);
    endtask

    logic [31:0] exp_q[$];
    int sent, rcvd, cyc;
    logic [31:0] front;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_ex.in_valid = 1'b0;
        id_ex.rd_addr = 5'd3;
        id_ex.reg_write = 1'b1;
        ex_mem.out_ready = 1'b0;
        set_beat(4'h0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("rst_valid", 32'(ex_mem.out_valid), 32'd0);
        chk("rst_ready", 32'(id_ex.in_ready), 32'd1);
        chk("rst_result", ex_mem.alu_result, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Beat held under backpressure, then asynchronous reset mid-cycle
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h200, 32'h11, 32'h22, 32'h0);
        id_ex.in_valid = 1'b1;
        step();
        id_ex.in_valid = 1'b0;
        chk("held_valid", 32'(ex_mem.out_valid), 32'd1);
        chk("held_result", ex_mem.alu_result, 32'h33);
        chk("held_store", ex_mem.store_data, 32'h22);
        chk("held_rd", 32'(ex_mem.rd_addr_o), 32'd3);
        chk("held_we", 32'(ex_mem.reg_write_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ex_mem.out_valid), 32'd0);
        chk("arst_result", ex_mem.alu_result, 32'd0);
        chk("arst_target", ex_mem.branch_target, 32'd0);
        chk("arst_store", ex_mem.store_data, 32'd0);
        chk("arst_we", 32'(ex_mem.reg_write_o), 32'd0);
        chk("arst_ready", 32'(id_ex.in_ready), 32'd1);
        #1 rst = 1'b0;

        alu_case("add_5_7", ALU_ADD, 1'b0, 32'd5, 32'd7, 32'h0, 32'd12);
        chk("add_valid", 32'(ex_mem.out_valid), 32'd1);

        alu_case("sub", ALU_SUB, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'h7FFF_FFFC);
        alu_case("sra", ALU_SRA, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'hF800_0000);
        alu_case("srl", ALU_SRL, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'h0800_0000);
        alu_case("slt", ALU_SLT, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'd1);
        alu_case("sltu", ALU_SLTU, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'd0);
        alu_case("code_f", 4'hF, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'd0);
        alu_case("code_a", 4'hA, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'd0);
        alu_case("and", ALU_AND, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000);
        alu_case("or", ALU_OR, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'hFFF0);
        alu_case("xor", ALU_XOR, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0FF0);
        alu_case("sll_imm31", ALU_SLL, 1'b1, 32'h1, 32'h0, 32'h1F, 32'h8000_0000);
        alu_case("sll_shamt5b", ALU_SLL, 1'b1, 32'h1, 32'h3, 32'h24, 32'h10);
        alu_case("add_wrap", ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        chk("add_wrap_zero", 32'(ex_mem.zero), 32'd1);
        alu_case("add_imm", ALU_ADD, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFE, 32'd8);
        chk("nonzero_flag", 32'(ex_mem.zero), 32'd0);

        br_case("beq_eq", ALU_SUB, F3_BEQ, 1'b1, 32'd7, 32'd7, 1'b1);
        br_case("bne_ne", ALU_SUB, F3_BNE, 1'b1, 32'd7, 32'd8, 1'b1);
        br_case("bge_m1_1", ALU_SLT, F3_BGE, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        br_case("bgeu_big_1", ALU_SLTU, F3_BGEU, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        br_case("blt_m1_1", ALU_SLT, F3_BLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        br_case("f3_010", ALU_SUB, 3'b010, 1'b1, 32'd7, 32'd7, 1'b0);
        br_case("not_branch", ALU_SUB, F3_BEQ, 1'b0, 32'd7, 32'd7, 1'b0);

        // Backpressure: beat1 held three cycles while beat2 waits
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0);
        run_beat();
        chk("bp_first", ex_mem.alu_result, 32'd2);
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0);
        id_ex.in_valid = 1'b1;
        ex_mem.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", 32'(id_ex.in_ready), 32'd0);
            chk("bp_valid", 32'(ex_mem.out_valid), 32'd1);
            chk("bp_hold", ex_mem.alu_result, 32'd2);
        end
        ex_mem.out_ready = 1'b1;
        #1;
        chk("bp_ready_up", 32'(id_ex.in_ready), 32'd1);
        step();
        id_ex.in_valid = 1'b0;
        chk("bp_second", ex_mem.alu_result, 32'd6);
        chk("bp_second_valid", 32'(ex_mem.out_valid), 32'd1);

        // Flush concurrent with an accept
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'd9, 32'd9, 32'h0);
        id_ex.in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_ex.in_valid = 1'b0;
        chk("flush_accept", 32'(ex_mem.out_valid), 32'd0);

        // Flush while a beat is stalled
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'h40, 32'h2, 32'h0);
        run_beat();
        ex_mem.out_ready = 1'b0;
        step();
        chk("stall_pre", 32'(ex_mem.out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_stall", 32'(ex_mem.out_valid), 32'd0);

        // Idle flush leaves the stage unchanged
        set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'h70, 32'h7, 32'h0);
        run_beat();
        step();
        chk("idle_pre", 32'(ex_mem.out_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("idle_flush_valid", 32'(ex_mem.out_valid), 32'd0);
        chk("idle_flush_data", ex_mem.alu_result, 32'h77);

        // Random-stall run: order and count of 100 beats
        sent = 0;
        rcvd = 0;
        cyc = 0;
        while (rcvd < 100 && cyc < 2000) begin
            id_ex.in_valid = (sent < 100) && ($urandom_range(3) != 0);
            ex_mem.out_ready = ($urandom_range(2) != 0);
            set_beat(ALU_ADD, 1'b0, 3'b000, 1'b0, 32'h0, 32'(sent), 32'(sent * 3), 32'h0);
            @(negedge clk);
            if (ex_mem.out_valid && ex_mem.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra", 32'd1, 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    chk("rnd_beat", ex_mem.alu_result, front);
                end
                rcvd++;
            end
            if (id_ex.in_valid && id_ex.in_ready) begin
                exp_q.push_back(32'(sent * 4));
                sent++;
            end
            step();
            cyc++;
        end
        id_ex.in_valid = 1'b0;
        chk("rnd_count", 32'(rcvd), 32'd100);
        chk("rnd_leftover", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RV32I core: one registered stage that sits directly downstream of the ALU control decoder. It takes the decoded 4-bit `ALUctrl`, operands and branch information from the ID/EX side, computes the ALU result and branch decision, and holds them in the EX/MEM output register. A valid/ready handshake on both sides provides backpressure, and a flush input squashes the stage on redirects.

## Interface
- `DATA_WIDTH`, 32: operand/result width; shift amount is always `[4:0]`.
- `REG_ADDR_W`, 5: destination register address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: squash the input beat and the held output beat.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage can accept a beat this cycle.
- `ALUctrl` in 4: operation code from the ALU control decoder.
- `ALUsrc` in 1: 1 selects `imm` as operand B, 0 selects `rs2_data`.
- `funct3` in 3: branch condition selector.
- `is_branch` in 1: beat is a B-type instruction.
- `pc` in DATA_WIDTH: instruction address.
- `rs1_data`, `rs2_data`, `imm` in DATA_WIDTH: operands.
- `rd_addr` in REG_ADDR_W: destination register.
- `reg_write` in 1: writeback enable.
- `out_valid` out 1: EX/MEM beat present.
- `out_ready` in 1: downstream accepts the beat.
- `alu_result` out DATA_WIDTH: registered ALU result.
- `zero` out 1: registered `(alu_result == 0)`.
- `branch_taken` out 1: registered branch decision.
- `branch_target` out DATA_WIDTH: registered `pc + imm`, wrapping modulo 2^DATA_WIDTH.
- `store_data` out DATA_WIDTH: registered `rs2_data`.
- `rd_addr_o` out REG_ADDR_W, `reg_write_o` out 1: registered passthrough.

## Operation
- Operand A is `rs1_data`. Operand B is `imm` when `ALUsrc` is 1, otherwise `rs2_data`.
- ALUctrl encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra, using shift amount `B[4:0]`.
  - 1000 slt (signed), 1001 sltu (unsigned); result is zero-extended 0/1.
  - Codes 1010–1111 give a result of 0.
- Add and sub wrap modulo 2^DATA_WIDTH.
- Branch decision is 0 unless `is_branch` is 1. When `is_branch` is 1, by funct3:
  - 000 taken when `zero`; 001 taken when not `zero`.
  - 100/110 taken when `result[0]` is 1; 101/111 taken when `result[0]` is 0.
  - Any other funct3 is not taken.
- Handshake:
  - `in_ready = !out_valid || out_ready` (no skid buffer).
  - A beat is accepted when `in_valid && in_ready && !flush`.
  - When a beat is accepted, every output register loads and `out_valid` becomes 1.
  - When `out_valid && out_ready` and no new beat is accepted, `out_valid` becomes 0.
  - While `out_valid && !out_ready`, all outputs hold stable.
- Flush:
  - The next cycle has `out_valid` = 0, whatever the values of `in_valid` and `out_ready`.
  - Data registers are don't-care after a flush, but must not change while a beat is held.
  - Flush wins over a simultaneous accept.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- `in_ready` is combinational from `out_valid` and `out_ready` only; there is no path from `in_valid` to `in_ready`.
- Reset (asynchronous, mid-operation included): `out_valid` = 0 and every data output = 0 immediately. `in_ready` = 1 during and after reset.
- The first accept is possible on the first rising edge after `rst` deasserts.

## Structure
- Shared package `alu_pkg`: ALUctrl codes as a `typedef enum logic [3:0]` (`ALU_ADD` … `ALU_SLTU`), plus funct3 branch constants. The ALU control decoder must also import this package.
- Sub-module `alu`: purely combinational, ports `a`, `b`, `ALUctrl`, `result`, `zero`.
- `ex_stage` holds the operand mux, branch logic, handshake and EX/MEM register.

## Test plan
- Reset asserted mid-stream with `out_valid` = 1: outputs go to 0 without waiting for a clock edge, `in_ready` = 1. After release, beat add 5+7 gives `alu_result` = 12 one cycle later.
- ALU sweep with `ALUsrc` = 0, A = 0x80000000, B = 0x00000004:
  - sub = 0x7FFFFFFC; sra = 0xF8000000; srl = 0x08000000.
  - slt = 1; sltu = 0; code 1111 = 0.
  - add with A = 0xFFFFFFFF, B = 1: result 0, `zero` = 1.
- Branches with `pc` = 0x100, `imm` = 0xFFFFFFF0:
  - beq on equal operands: taken, target 0xF0.
  - bge with −1 vs 1 (ALUctrl slt): not taken.
  - bgeu with 0xFFFFFFFF vs 1 (ALUctrl sltu): taken.
  - funct3 = 010: not taken.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1. `in_ready` = 0 and outputs stay stable; the second beat appears exactly one cycle after `out_ready` rises. No beat is lost or duplicated over a 100-beat random-stall run.
- Flush in the same cycle as an accept, and again while a beat is stalled: `out_valid` = 0 next cycle in both cases. Flush with `in_valid` = 0 and `out_valid` = 0: no change.
